// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and constants for the cache block fill controller.
// A block is 16 bytes, held as eight 16-bit words.
package cache_fill_fsm_pkg;

    localparam int WORDS_PER_BLOCK   = 8;
    localparam int MEM_LATENCY       = 4;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int ADDR_W            = 16;
    localparam int CNT_W             = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Byte address of word idx inside the block; the offset never carries into the block bits.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return {base[ADDR_W-1:BLOCK_OFFSET_BITS], idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// Small up-counter with synchronous clear (priority over enable) and async reset.
module word_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block fill: issues eight back-to-back word reads and writes each
// returned word into the data array, writing the tag with the last word.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = cache_fill_fsm_pkg::WORDS_PER_BLOCK,
    parameter int MEM_LATENCY     = cache_fill_fsm_pkg::MEM_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        mem_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [15:0] cache_word_address,
    output logic        write_tag_array
);

    import cache_fill_fsm_pkg::*;

    localparam int REQ = 0;
    localparam int RCV = 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

    // The counters are 3 bits wide, so only an eight-word block fits.
    if (WORDS_PER_BLOCK != 8 || MEM_LATENCY < 1) begin : g_param_check
        $error("cache_fill_fsm: WORDS_PER_BLOCK must be 8 and MEM_LATENCY at least 1");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              req_done_q, req_done_d;
    logic              accept_miss;
    logic [CNT_W-1:0]  cnt [2];
    logic              cnt_clr [2];
    logic              cnt_en [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        word_counter #(
            .WIDTH (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (cnt_clr[gi]),
            .en_i    (cnt_en[gi]),
            .count_o (cnt[gi])
        );
    end

    assign cnt_clr[REQ] = accept_miss;
    assign cnt_en[REQ]  = mem_read_en;
    assign cnt_clr[RCV] = accept_miss;
    assign cnt_en[RCV]  = write_data_array;

    always_comb begin
        state_d            = state_q;
        base_d             = base_q;
        req_done_d         = req_done_q;
        accept_miss        = 1'b0;
        fsm_busy           = 1'b0;
        mem_read_en        = 1'b0;
        memory_address     = '0;
        write_data_array   = 1'b0;
        cache_word_address = '0;
        write_tag_array    = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    accept_miss = 1'b1;
                    base_d      = {miss_address[ADDR_W-1:BLOCK_OFFSET_BITS], BLOCK_OFFSET_BITS'(0)};
                    req_done_d  = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                fsm_busy = 1'b1;
                // The request counter wraps to 0 after the last word, so a flag marks completion.
                if (!req_done_q) begin
                    mem_read_en    = 1'b1;
                    memory_address = word_addr(base_q, cnt[REQ]);
                    if (cnt[REQ] == LAST_WORD) begin
                        req_done_d = 1'b1;
                    end
                end
                if (memory_data_valid) begin
                    write_data_array   = 1'b1;
                    cache_word_address = word_addr(base_q, cnt[RCV]);
                    if (cnt[RCV] == LAST_WORD) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            req_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            req_done_q <= req_done_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a responsive memory model and a
// per-cycle expectation built from the fill schedule.
module tb_cache_fill_fsm;

    localparam int LAT   = 4;
    localparam int WORDS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] cache_word_address;
    logic        write_tag_array;

    int vectors = 0;
    int miscompares = 0;
    int cur_cycle = 0;

    cache_fill_fsm #(
        .WORDS_PER_BLOCK (WORDS),
        .MEM_LATENCY     (LAT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .miss_detected      (miss_detected),
        .miss_address       (miss_address),
        .memory_data_valid  (memory_data_valid),
        .fsm_busy           (fsm_busy),
        .mem_read_en        (mem_read_en),
        .memory_address     (memory_address),
        .write_data_array   (write_data_array),
        .cache_word_address (cache_word_address),
        .write_tag_array    (write_tag_array)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cur_cycle, obs, exp);
        end
    endtask

    task automatic check_all(input logic busy, input logic rd, input logic [15:0] maddr,
                             input logic wd, input logic [15:0] waddr, input logic tag);
        check("fsm_busy",           16'(fsm_busy),         16'(busy));
        check("mem_read_en",        16'(mem_read_en),      16'(rd));
        check("memory_address",     memory_address,        maddr);
        check("write_data_array",   16'(write_data_array), 16'(wd));
        check("cache_word_address", cache_word_address,    waddr);
        check("write_tag_array",    16'(write_tag_array),  16'(tag));
    endtask

    // mode 0: data returns LAT cycles after each request; 1: every other cycle; 2: random stalls.
    // armed: the previous fill left a miss held in IDLE, so the next edge starts this fill.
    task automatic run_fill(input logic [15:0] addr, input int mode, input logic armed,
                            input logic hold, input logic [15:0] next_addr, input int abort_at);
        logic [15:0] base;
        int          t [WORDS];
        int          last;
        int          nv;
        logic        v;
        base = addr & 16'hFFF0;
        for (int j = 0; j < WORDS; j++) begin
            int earliest;
            earliest = j + LAT;
            if (j > 0 && t[j-1] + 1 > earliest) earliest = t[j-1] + 1;
            case (mode)
                1:       t[j] = LAT + 2 * j;
                2:       t[j] = earliest + int'($urandom_range(0, 2));
                default: t[j] = earliest;
            endcase
        end
        last = t[WORDS-1];
        nv   = 0;
        $display("fill miss=%h base=%h mode=%0d abort_at=%0d done_cycle=%0d", addr, base, mode, abort_at, last + 1);
        if (!armed) begin
            @(posedge clk);
            #1;
            rst_n             = 1'b1;
            miss_detected     = 1'b1;
            miss_address      = addr;
            memory_data_valid = 1'b0;
            @(negedge clk);
            cur_cycle = -1;
            check_all(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        end
        for (int c = 0; c <= last + 1; c++) begin
            @(posedge clk);
            #1;
            if (hold) begin
                miss_detected = 1'b1;
                miss_address  = next_addr;
            end else begin
                miss_detected = (c <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
                miss_address  = 16'($urandom);
            end
            v = (nv < WORDS) && (c == t[nv]);
            memory_data_valid = v;
            @(negedge clk);
            cur_cycle = c;
            check_all(c <= last, c < WORDS, (c < WORDS) ? base + 16'(2 * c) : 16'h0,
                      v, v ? base + 16'(2 * nv) : 16'h0, v && (nv == WORDS - 1));
            if (v) nv++;
            if (abort_at > 0 && v && nv == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_all(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
                @(posedge clk);
                #1;
                memory_data_valid = 1'b0;
                miss_detected     = 1'b0;
                return;
            end
        end
        memory_data_valid = 1'b0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst_n             = 1'b1;
            miss_detected     = 1'b0;
            miss_address      = 16'($urandom);
            memory_data_valid = 1'b1;
            @(negedge clk);
            cur_cycle = i;
            check_all(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        end
        memory_data_valid = 1'b0;
        $display("idle valid pulses=%0d", n);
    endtask

    initial begin
        miss_detected     = 1'b1;
        miss_address      = 16'h5555;
        memory_data_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_all(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        end
        $display("reset held with miss and valid asserted");

        run_fill(16'h1234, 0, 1'b0, 1'b0, 16'h0, 0);
        run_idle(4);
        run_fill(16'hFFFF, 0, 1'b0, 1'b0, 16'h0, 0);
        run_fill(16'h2000, 0, 1'b0, 1'b1, 16'h4000, 0);
        run_fill(16'h4000, 2, 1'b1, 1'b0, 16'h0, 0);
        run_fill(16'($urandom), 0, 1'b0, 1'b0, 16'h0, 5);
        run_fill(16'h9ABC, 0, 1'b0, 1'b0, 16'h0, 0);
        run_idle(3);
        run_fill(16'h8A5C, 1, 1'b0, 1'b0, 16'h0, 0);
        for (int k = 0; k < 6; k++) begin
            run_fill(16'($urandom), 2, 1'b0, 1'b0, 16'h0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
